acia_key_sequencer: RTL and testbench

Bus-master sequencer for the CoCo-side 6551 interface. It issues the 4-byte status-register key (0x55, 0xAA, 0x01, 0x01/0x00) that locks or unlocks the fast-ACIA command register. It can optionally write and read back the command register. The block sits between a config controller and the ACIA wrapper's CPU port (ce/r_w/address/data), and is the initiator end of the lock protocol the wrapper responds to.

---
 rtl/acia_pkg.sv | 39 +++
 rtl/acia_key_sequencer_if.sv | 26 ++
 rtl/acia_key_sequencer_bus_access.sv | 96 +++++++++
 rtl/acia_key_sequencer.sv | 133 +++++++++++++
 tb/tb_acia_key_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/acia_pkg.sv
// Shared constants and state encodings for the ACIA key sequencer.
package acia_pkg;

    // Wrapper register selects
    localparam logic [1:0] ACIA_STATUS = 2'd1;
    localparam logic [1:0] ACIA_CMD    = 2'd3;

    // Status-register key bytes
    localparam logic [7:0] KEY_0      = 8'h55;
    localparam logic [7:0] KEY_1      = 8'hAA;
    localparam logic [7:0] KEY_2      = 8'h01;
    localparam logic [7:0] KEY_LOCK   = 8'h01;
    localparam logic [7:0] KEY_UNLOCK = 8'h00;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StKey0,
        StKey1,
        StKey2,
        StKey3,
        StCmd,
        StVerify,
        StDone
    } seq_state_e;

    // Phases of a single bus access
    typedef enum logic [1:0] {
        PhSetup,
        PhStrobe,
        PhGap
    } phase_e;

    // Fourth key byte selects lock or unlock
    function automatic logic [7:0] key_final(input logic lock);
        return lock ? KEY_LOCK : KEY_UNLOCK;
    endfunction

endpackage

// File: rtl/acia_key_sequencer_if.sv
// CPU-port bus between the key sequencer (master) and the ACIA wrapper (slave).
interface acia_key_sequencer_if;

    logic       ce;
    logic       r_w;
    logic [1:0] address;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    modport master (
        output ce,
        output r_w,
        output address,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  ce,
        input  r_w,
        input  address,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/acia_key_sequencer_bus_access.sv
// One SETUP / STROBE / GAP access on the wrapper CPU port. The access runs while
// go is held; ack pulses on the last GAP cycle and the next access may start
// with its SETUP on the following cycle.
module bus_access
    import acia_pkg::*;
#(
    parameter int unsigned CE_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic       go,
    input  logic       write,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    acia_key_sequencer_if.master bus
);

    localparam int unsigned MaxCycles = (CE_CYCLES > GAP_CYCLES) ? CE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] CeLast  = CntW'(CE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      rdata_q;
    logic            strobe_last;

    assign strobe_last = go && (phase_q == PhStrobe) && (cnt_q == CeLast);
    assign rdata       = rdata_q;

    // Phase register and read-data capture
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            phase_q <= PhSetup;
            cnt_q   <= '0;
            rdata_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (strobe_last) begin
                rdata_q <= bus.bus_rdata;
            end
        end
    end

    // Phase sequencing; dropping go parks the engine in SETUP
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        if (!go) begin
            phase_d = PhSetup;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                PhSetup: begin
                    phase_d = PhStrobe;
                    cnt_d   = '0;
                end
                PhStrobe: begin
                    if (cnt_q == CeLast) begin
                        phase_d = PhGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                PhGap: begin
                    if (cnt_q == GapLast) begin
                        phase_d = PhSetup;
                        cnt_d   = '0;
                        ack     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    phase_d = PhSetup;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Bus drive: access fields held for the whole access, idle values otherwise
    always_comb begin
        bus.ce        = go && (phase_q == PhStrobe);
        bus.r_w       = go ? ~write : 1'b1;
        bus.address   = go ? addr : 2'd0;
        bus.bus_wdata = (go && write) ? wdata : 8'h00;
    end

endmodule

// File: rtl/acia_key_sequencer.sv
// Issues the status-register key that locks/unlocks the fast-ACIA command
// register, optionally writing and reading back the command register.
module acia_key_sequencer
    import acia_pkg::*;
#(
    parameter int unsigned CE_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic       start,
    input  logic       lock,
    input  logic       cmd_en,
    input  logic [7:0] cmd_value,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] readback,
    acia_key_sequencer_if.master bus
);

    seq_state_e state_q, state_d;
    logic       lock_q;
    logic       cmd_en_q;
    logic [7:0] cmd_value_q;
    logic       error_q;
    logic [7:0] readback_q;

    logic       go;
    logic       acc_write;
    logic [1:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       accept;

    assign accept   = (state_q == StIdle) && start;
    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);
    assign error    = error_q;
    assign readback = readback_q;

    bus_access #(
        .CE_CYCLES  (CE_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_bus_access (
        .clock  (clock),
        ._reset (_reset),
        .go     (go),
        .write  (acc_write),
        .addr   (acc_addr),
        .wdata  (acc_wdata),
        .ack    (ack),
        .rdata  (rdata),
        .bus    (bus)
    );

    // State, captured request and verify result
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_q     <= StIdle;
            lock_q      <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_value_q <= 8'h00;
            error_q     <= 1'b0;
            readback_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lock_q      <= lock;
                cmd_en_q    <= cmd_en;
                cmd_value_q <= cmd_value;
                error_q     <= 1'b0;
            end
            if ((state_q == StVerify) && ack) begin
                readback_q <= rdata;
                error_q    <= (rdata != cmd_value_q);
            end
        end
    end

    // Access descriptor for the current state
    always_comb begin
        go        = 1'b0;
        acc_write = 1'b0;
        acc_addr  = 2'd0;
        acc_wdata = 8'h00;
        case (state_q)
            StKey0:   begin go = 1'b1; acc_write = 1'b1; acc_addr = ACIA_STATUS; acc_wdata = KEY_0; end
            StKey1:   begin go = 1'b1; acc_write = 1'b1; acc_addr = ACIA_STATUS; acc_wdata = KEY_1; end
            StKey2:   begin go = 1'b1; acc_write = 1'b1; acc_addr = ACIA_STATUS; acc_wdata = KEY_2; end
            StKey3:   begin
                go        = 1'b1;
                acc_write = 1'b1;
                acc_addr  = ACIA_STATUS;
                acc_wdata = key_final(lock_q);
            end
            StCmd:    begin go = 1'b1; acc_write = 1'b1; acc_addr = ACIA_CMD; acc_wdata = cmd_value_q; end
            StVerify: begin go = 1'b1; acc_addr = ACIA_CMD; end
            default:  ;
        endcase
    end

    // Sequencing: locking writes the command before the key so it lands
    // while still unlocked; unlocking keys first so the write gets through
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (cmd_en && lock) ? StCmd : StKey0;
                end
            end
            StKey0: if (ack) state_d = StKey1;
            StKey1: if (ack) state_d = StKey2;
            StKey2: if (ack) state_d = StKey3;
            StKey3: begin
                if (ack) begin
                    if (!cmd_en_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = lock_q ? StVerify : StCmd;
                    end
                end
            end
            StCmd:    if (ack) state_d = lock_q ? StKey0 : StVerify;
            StVerify: if (ack) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_acia_key_sequencer.sv
// Randomized self-checking bench: two sequencers (default and 3/2 timing) on
// a wrapper model; accesses are logged per instance and compared with an
// expected access list built from the lock/command ordering rules.
module tb_acia_key_sequencer;

    localparam int unsigned CeA = 2, GapA = 1, CeB = 3, GapB = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n     [2];
    logic       start_s   [2];
    logic       lock_s    [2];
    logic       cmd_en_s  [2];
    logic [7:0] cmd_val_s [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic       error_s   [2];
    logic [7:0] rb_s      [2];

    acia_key_sequencer_if bif0 ();
    acia_key_sequencer_if bif1 ();

    acia_key_sequencer #(.CE_CYCLES(CeA), .GAP_CYCLES(GapA)) u_dut0 (
        .clock(clock), ._reset(rst_n[0]), .start(start_s[0]), .lock(lock_s[0]),
        .cmd_en(cmd_en_s[0]), .cmd_value(cmd_val_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .error(error_s[0]), .readback(rb_s[0]), .bus(bif0)
    );

    acia_key_sequencer #(.CE_CYCLES(CeB), .GAP_CYCLES(GapB)) u_dut1 (
        .clock(clock), ._reset(rst_n[1]), .start(start_s[1]), .lock(lock_s[1]),
        .cmd_en(cmd_en_s[1]), .cmd_value(cmd_val_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .error(error_s[1]), .readback(rb_s[1]), .bus(bif1)
    );

    // Wrapper model: command register echoes writes, or returns 0x10 when bad
    logic [7:0]  shadow [2] = '{8'h00, 8'h00};
    logic        bad    [2];
    logic        ce_w   [2];
    logic [10:0] sig_w  [2];

    assign bif0.bus_rdata = bad[0] ? 8'h10 : shadow[0];
    assign bif1.bus_rdata = bad[1] ? 8'h10 : shadow[1];
    assign ce_w[0]  = bif0.ce;
    assign ce_w[1]  = bif1.ce;
    assign sig_w[0] = {bif0.r_w, bif0.address, bif0.bus_wdata};
    assign sig_w[1] = {bif1.r_w, bif1.address, bif1.bus_wdata};

    // Bus monitor: logs one entry per ce pulse with its length and counts
    // any change of r_w/address/data from SETUP through the first GAP cycle
    logic        prev_ce  [2] = '{1'b0, 1'b0};
    logic [10:0] prev_sig [2];
    logic [10:0] log_sig  [2][8];
    int          log_len  [2][8];
    int          log_n    [2];
    int          cur_len  [2];
    int          stab_err [2];
    logic        clr      [2];

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            prev_ce[i]  <= ce_w[i];
            prev_sig[i] <= sig_w[i];
            if (clr[i]) begin
                log_n[i]    <= 0;
                stab_err[i] <= 0;
                cur_len[i]  <= 0;
            end else if (ce_w[i]) begin
                if (!prev_ce[i]) begin
                    cur_len[i] <= 1;
                    if (log_n[i] < 8) log_sig[i][log_n[i]] <= sig_w[i];
                    if (!sig_w[i][10] && sig_w[i][9:8] == 2'd3) shadow[i] <= sig_w[i][7:0];
                end else begin
                    cur_len[i] <= cur_len[i] + 1;
                end
                if (sig_w[i] != prev_sig[i]) stab_err[i] <= stab_err[i] + 1;
            end else if (prev_ce[i]) begin
                if (log_n[i] < 8) log_len[i][log_n[i]] <= cur_len[i];
                log_n[i] <= log_n[i] + 1;
                if (sig_w[i] != prev_sig[i]) stab_err[i] <= stab_err[i] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int op_id    = 0;
    logic [7:0] exp_rb [2] = '{8'h00, 8'h00};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int i, input string tag);
        logic [10:0] s;
        s = sig_w[i];
        check_eq({tag, "_ce"}, ce_w[i], 0);
        check_eq({tag, "_bus"}, s, {1'b1, 2'd0, 8'h00});
        check_eq({tag, "_busy"}, busy_s[i], 0);
        check_eq({tag, "_done"}, done_s[i], 0);
        check_eq({tag, "_error"}, error_s[i], 0);
        check_eq({tag, "_readback"}, rb_s[i], 0);
    endtask

    task automatic clear_log(input int i);
        @(posedge clock);
        clr[i] = 1'b1;
        @(posedge clock);
        clr[i] = 1'b0;
    endtask

    // One operation; also pokes start during DONE (and optionally mid-op),
    // both of which must be ignored
    task automatic run_op(input int i, input logic lk, input logic c_en, input logic [7:0] val,
                          input logic bd, input logic poke);
        logic [10:0] exp_sig [8];
        int   n, a, ce_n, lat, done_cnt;
        logic exp_err, lower;
        string tg;
        ce_n = (i == 0) ? CeA : CeB;
        a    = 1 + ce_n + ((i == 0) ? GapA : GapB);
        op_id++;
        n = 0;
        if (c_en && lk) begin exp_sig[n] = {1'b0, 2'd3, val}; n++; end
        exp_sig[n] = {1'b0, 2'd1, 8'h55}; n++;
        exp_sig[n] = {1'b0, 2'd1, 8'hAA}; n++;
        exp_sig[n] = {1'b0, 2'd1, 8'h01}; n++;
        exp_sig[n] = {1'b0, 2'd1, lk ? 8'h01 : 8'h00}; n++;
        if (c_en && !lk) begin exp_sig[n] = {1'b0, 2'd3, val}; n++; end
        if (c_en) begin exp_sig[n] = {1'b1, 2'd3, 8'h00}; n++; end
        if (c_en) exp_rb[i] = bd ? 8'h10 : val;
        exp_err = c_en && (exp_rb[i] != val);

        bad[i] = bd;
        clear_log(i);
        @(negedge clock);
        start_s[i] = 1'b1; lock_s[i] = lk; cmd_en_s[i] = c_en; cmd_val_s[i] = val;
        lat = -1; done_cnt = 0; lower = 1'b0;
        for (int k = 1; k <= 6 * a + 12; k++) begin
            @(negedge clock);
            if (lower) begin start_s[i] = 1'b0; lower = 1'b0; end
            if (k == 1) begin
                tg = $sformatf("op%0d_busy_rise", op_id);
                check_eq(tg, busy_s[i], 1);
                start_s[i] = 1'b0;
                cmd_val_s[i] = ~val;
                lock_s[i] = ~lk;
            end
            if (poke && k == 5) start_s[i] = 1'b1;
            if (poke && k == 6) start_s[i] = 1'b0;
            if (done_s[i]) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    tg = $sformatf("op%0d_error", op_id);
                    check_eq(tg, error_s[i], exp_err);
                    tg = $sformatf("op%0d_readback", op_id);
                    check_eq(tg, rb_s[i], exp_rb[i]);
                    tg = $sformatf("op%0d_busy_at_done", op_id);
                    check_eq(tg, busy_s[i], 0);
                    start_s[i] = 1'b1;
                    lower = 1'b1;
                end
            end
        end
        tg = $sformatf("op%0d_latency", op_id);
        check_eq(tg, lat, n * a + 1);
        tg = $sformatf("op%0d_done_pulses", op_id);
        check_eq(tg, done_cnt, 1);
        tg = $sformatf("op%0d_access_count", op_id);
        check_eq(tg, log_n[i], n);
        tg = $sformatf("op%0d_bus_stable", op_id);
        check_eq(tg, stab_err[i], 0);
        tg = $sformatf("op%0d_idle_busy", op_id);
        check_eq(tg, busy_s[i], 0);
        for (int e = 0; e < n && e < 8; e++) begin
            if (exp_sig[e][10]) begin
                tg = $sformatf("op%0d_acc%0d_read", op_id, e);
                check_eq(tg, log_sig[i][e][10:8], exp_sig[e][10:8]);
            end else begin
                tg = $sformatf("op%0d_acc%0d_write", op_id, e);
                check_eq(tg, log_sig[i][e], exp_sig[e]);
            end
            tg = $sformatf("op%0d_acc%0d_ce_len", op_id, e);
            check_eq(tg, log_len[i][e], ce_n);
        end
        tg = $sformatf("op%0d_error_held", op_id);
        check_eq(tg, error_s[i], exp_err);
    endtask

    // Reset asserted during the KEY2 strobe of an unlock-with-command op
    task automatic reset_mid_key2();
        logic found;
        int   n_at;
        int   dn;
        found = 1'b0;
        clear_log(0);
        @(negedge clock);
        start_s[0] = 1'b1; lock_s[0] = 1'b0; cmd_en_s[0] = 1'b1; cmd_val_s[0] = 8'h3C;
        @(negedge clock);
        start_s[0] = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (ce_w[0] && sig_w[0] == {1'b0, 2'd1, 8'h01}) found = 1'b1;
            else @(negedge clock);
        end
        check_eq("rst_key2_reached", found, 1);
        rst_n[0] = 1'b0;
        #1;
        exp_rb[0] = 8'h00;
        check_reset(0, "rst_mid_op");
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done_s[0]) dn++;
        end
        rst_n[0] = 1'b1;
        n_at = log_n[0];
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done_s[0]) dn++;
        end
        check_eq("rst_no_done", dn, 0);
        check_eq("rst_no_more_access", log_n[0], n_at);
        check_eq("rst_idle_busy", busy_s[0], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; start_s[i] = 1'b0; lock_s[i] = 1'b0; cmd_en_s[i] = 1'b0;
            cmd_val_s[i] = 8'h00; bad[i] = 1'b0; clr[i] = 1'b0;
        end
        #1;
        check_reset(0, "reset0");
        check_reset(1, "reset1");
        repeat (3) @(negedge clock);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clock);

        run_op(0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);  // unlock + command
        run_op(0, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b0);  // lock + command
        run_op(0, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);  // verify mismatch
        run_op(0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);  // key only
        reset_mid_key2();
        run_op(0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);  // clean sequence after reset
        run_op(1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);  // 3/2 timing, start while busy
        run_op(1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] v;
            v = 8'($urandom);
            run_op(r % 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v,
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
